branch_resolve_bht: RTL and testbench

Parametrised branch resolution unit with a direct-mapped branch history table (BHT) of saturating counters. It replaces the always-not-taken scheme. The ID stage reads a taken/not-taken prediction for each fetched PC. The EX stage resolves all six RV32 conditional branches against that prediction and issues a registered one-cycle redirect/flush when the prediction was wrong. Wrong-path instructions are squashed, and branch and mispredict statistics are kept.

---
 rtl/rv32_pkg.sv | 27 ++
 rtl/bht_sat_table.sv | 49 ++++
 rtl/branch_resolve_bht.sv | 121 ++++++++++++
 tb/tb_branch_resolve_bht.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: RV32 encodings shared by the branch unit and its neighbours.
//   OPC_BRANCH, the six conditional-branch funct3 codes, the forwarding-select
//   type, and a helper that screens out the reserved funct3 values 010/011.
package rv32_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_RS1  = 2'd1,
        FWD_RS2  = 2'd2,
        FWD_BOTH = 2'd3
    } fwd_sel_t;

    // funct3 010 and 011 are unused under the BRANCH opcode.
    function automatic logic is_branch_f3(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

endpackage

// File: rtl/bht_sat_table.sv
// bht_sat_table: direct-mapped table of saturating counters.
//   clk, rst_n          : clock, asynchronous active-low reset
//   rd_idx / rd_taken   : combinational lookup, returns counter MSB
//   upd_en, upd_idx,
//   upd_taken           : saturating +1 (taken) / -1 (not taken) at clock edge
// A same-index read and update in one cycle returns the pre-update value.
module bht_sat_table #(
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    // Weakly not taken: 2^(CTR_BITS-1) - 1.
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;

    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [CTR_BITS-1:0] upd_cur;

    assign rd_taken = ctr_q[rd_idx][CTR_BITS-1];
    assign upd_cur  = ctr_q[upd_idx];

    // NOTE: this array is built from flops, not a RAM macro, so it can and
    // must be reset: every counter has to start weakly not taken.
    // NOTE: sequential state uses non-blocking assignments so every reader in
    // the same edge sees the pre-update value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (upd_en) begin
            if (upd_taken && (upd_cur != CTR_MAX)) begin
                ctr_q[upd_idx] <= upd_cur + CTR_BITS'(1);
            end else if (!upd_taken && (upd_cur != '0)) begin
                ctr_q[upd_idx] <= upd_cur - CTR_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/branch_resolve_bht.sv
// branch_resolve_bht: RV32 conditional-branch resolution with a BHT predictor.
//   pred_pc -> pred_taken          : 0-cycle BHT lookup for the fetch/decode PC
//   ex_* , rs1, rs2, fwd_*         : EX-stage instruction and operands
//   redirect, redirect_pc, flush   : registered one-cycle pulse on mispredict
//   branch_cnt, mispredict_cnt     : wrapping statistics
// The instruction in EX during the redirect cycle is wrong-path and is
// ignored entirely (no resolve, no BHT update, no count).
module branch_resolve_bht
    import rv32_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_BITS    = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic [31:0]      ex_instr,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [XLEN-1:0]  fwd_data,
    input  logic [1:0]       fwd_sel,
    output logic             redirect,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    fwd_sel_t        sel;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            is_branch;
    logic            resolve;
    logic            taken;
    logic            mispredict;
    logic [XLEN-1:0] next_pc;
    logic            squash_q;
    logic            unused_bits;

    assign opcode = ex_instr[6:0];
    assign funct3 = ex_instr[14:12];
    assign sel    = fwd_sel_t'(fwd_sel);

    assign op_a = (sel == FWD_RS1 || sel == FWD_BOTH) ? fwd_data : rs1;
    assign op_b = (sel == FWD_RS2 || sel == FWD_BOTH) ? fwd_data : rs2;

    assign is_branch = ex_valid && (opcode == OPC_BRANCH) && is_branch_f3(funct3);
    assign resolve   = is_branch && !squash_q;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and infers a latch.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (op_a == op_b);
            F3_BNE:  taken = (op_a != op_b);
            F3_BLT:  taken = ($signed(op_a) <  $signed(op_b));
            F3_BGE:  taken = ($signed(op_a) >= $signed(op_b));
            F3_BLTU: taken = (op_a <  op_b);
            F3_BGEU: taken = (op_a >= op_b);
            default: taken = 1'b0;
        endcase
    end

    assign mispredict = resolve && (taken != ex_pred_taken);
    assign next_pc    = taken ? ex_target : ex_pc + XLEN'(4);

    bht_sat_table #(
        .ENTRIES  (BHT_ENTRIES),
        .CTR_BITS (CTR_BITS)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (pred_pc[IDX_W+1:2]),
        .rd_taken  (pred_taken),
        .upd_en    (resolve),
        .upd_idx   (ex_pc[IDX_W+1:2]),
        .upd_taken (taken)
    );

    // squash_q marks the redirect cycle: the EX slot then holds the
    // instruction fetched down the wrong path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect       <= 1'b0;
            flush          <= 1'b0;
            redirect_pc    <= '0;
            squash_q       <= 1'b0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            redirect <= mispredict;
            flush    <= mispredict;
            squash_q <= mispredict;
            if (mispredict) begin
                redirect_pc <= next_pc;
            end
            if (resolve) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (mispredict) begin
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
            end
        end
    end

    // PC alignment/high bits and non-branch instruction fields are not needed.
    assign unused_bits = ^{pred_pc, ex_instr};

endmodule

// File: tb/tb_branch_resolve_bht.sv
// tb_branch_resolve_bht: directed plus randomized bench for branch_resolve_bht
// against a table-of-integers reference model.
module tb_branch_resolve_bht;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 64;
    localparam int CNT_W   = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [XLEN-1:0]  pred_pc;
    logic             pred_taken;
    logic             ex_valid;
    logic [31:0]      ex_instr;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_target;
    logic             ex_pred_taken;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [XLEN-1:0]  fwd_data;
    logic [1:0]       fwd_sel;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    branch_resolve_bht #(
        .XLEN(XLEN), .BHT_ENTRIES(ENTRIES), .CTR_BITS(2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_pc(ex_pc),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .rs1(rs1), .rs2(rs2), .fwd_data(fwd_data), .fwd_sel(fwd_sel),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: counters as plain integers 0..3, taken when >= 2.
    int          m_bht [ENTRIES];
    bit          m_redirect;
    logic [31:0] m_rpc;
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit m_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) <  $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a <  b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_bht[i] = 1;
        m_redirect = 1'b0;
        m_rpc      = '0;
        m_bcnt     = '0;
        m_mcnt     = '0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        bit          is_br;
        bit          tk;
        bit          nxt_redirect;
        int          k;
        f3    = ex_instr[14:12];
        is_br = ex_valid && (ex_instr[6:0] == 7'h63) && (f3 != 3'd2) && (f3 != 3'd3);
        nxt_redirect = 1'b0;
        if (is_br && !m_redirect) begin
            a  = fwd_sel[0] ? fwd_data : rs1;
            b  = fwd_sel[1] ? fwd_data : rs2;
            tk = m_taken(f3, a, b);
            m_bcnt = m_bcnt + 1;
            if (tk != ex_pred_taken) begin
                m_mcnt       = m_mcnt + 1;
                nxt_redirect = 1'b1;
                m_rpc        = tk ? ex_target : ex_pc + 32'd4;
            end
            k = m_idx(ex_pc);
            if (tk) m_bht[k] = (m_bht[k] < 3) ? m_bht[k] + 1 : 3;
            else    m_bht[k] = (m_bht[k] > 0) ? m_bht[k] - 1 : 0;
        end
        m_redirect = nxt_redirect;
    endtask

    task automatic compare_outputs();
        check("pred_taken", pred_taken, m_bht[m_idx(pred_pc)] >= 2);
        check("redirect", redirect, m_redirect);
        check("flush", flush, m_redirect);
        if (m_redirect) check("redirect_pc", redirect_pc, m_rpc);
        check("branch_cnt", branch_cnt, m_bcnt);
        check("mispredict_cnt", mispredict_cnt, m_mcnt);
    endtask

    // Called at a falling edge with inputs already driven; returns at the
    // next falling edge.
    task automatic cycle();
        #1;
        compare_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        ex_valid      = 1'b0;
        ex_instr      = 32'h0000_0013;
        ex_pred_taken = 1'b0;
        fwd_sel       = 2'd0;
    endtask

    task automatic set_br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic pt, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] fs, input logic [31:0] fd);
        ex_valid      = 1'b1;
        ex_instr      = {17'h0, f3, 5'h0, 7'h63};
        ex_pc         = pc;
        ex_target     = tgt;
        ex_pred_taken = pt;
        rs1           = a;
        rs2           = b;
        fwd_sel       = fs;
        fwd_data      = fd;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            5: return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        rst_n     = 1'b0;
        pred_pc   = 32'h100;
        ex_pc     = '0;
        ex_target = '0;
        rs1       = '0;
        rs2       = '0;
        fwd_data  = '0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state.
        check("rst_pred_taken", pred_taken, 1'b0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        check("rst_branch_cnt", branch_cnt, 32'h0);
        cycle();

        // BEQ 5==5 predicted not taken: mispredict to the target.
        set_br(3'b000, 32'h100, 32'h140, 1'b0, 32'd5, 32'd5, 2'd0, 32'd0);
        cycle();
        check("beq_redirect", redirect, 1'b1);
        check("beq_flush", flush, 1'b1);
        check("beq_redirect_pc", redirect_pc, 32'h140);
        check("beq_mispredict_cnt", mispredict_cnt, 32'd1);
        check("beq_pred_after", pred_taken, 1'b1);
        idle();
        cycle();

        // Four correctly predicted taken BEQs saturate the counter at 3.
        for (int i = 0; i < 4; i++) begin
            set_br(3'b000, 32'h100, 32'h140, 1'b1, 32'd5, 32'd5, 2'd0, 32'd0);
            cycle();
            check("sat_no_redirect", redirect, 1'b0);
        end
        check("sat_branch_cnt", branch_cnt, 32'd5);

        // Not taken while predicted taken: fall-through redirect, counter 3->2.
        set_br(3'b000, 32'h100, 32'h140, 1'b1, 32'd5, 32'd6, 2'd0, 32'd0);
        cycle();
        check("nt_redirect_pc", redirect_pc, 32'h104);
        check("nt_pred_after", pred_taken, 1'b1);
        check("nt_mispredict_cnt", mispredict_cnt, 32'd2);
        idle();
        cycle();

        // Signed vs unsigned compare on -1 vs 1.
        set_br(3'b100, 32'h200, 32'h300, 1'b0, 32'hFFFF_FFFF, 32'd1, 2'd0, 32'd0);
        cycle();
        check("blt_redirect_pc", redirect_pc, 32'h300);
        idle();
        cycle();
        set_br(3'b110, 32'h200, 32'h300, 1'b1, 32'hFFFF_FFFF, 32'd1, 2'd0, 32'd0);
        cycle();
        check("bltu_redirect_pc", redirect_pc, 32'h204);
        idle();
        cycle();

        // BGE with forwarded rs1 = 7 against rs2 = 7 (raw rs1 = 0 would fail).
        set_br(3'b101, 32'h200, 32'h400, 1'b0, 32'd0, 32'd7, 2'd1, 32'd7);
        cycle();
        check("bge_fwd_redirect_pc", redirect_pc, 32'h400);
        idle();
        cycle();

        // Mispredict then a valid BNE in the redirect cycle: squashed.
        set_br(3'b001, 32'h300, 32'h380, 1'b0, 32'd1, 32'd2, 2'd0, 32'd0);
        cycle();
        check("sq_redirect", redirect, 1'b1);
        check("sq_redirect_pc", redirect_pc, 32'h380);
        cycle();
        check("sq_no_redirect", redirect, 1'b0);
        check("sq_branch_cnt", branch_cnt, 32'd10);
        check("sq_mispredict_cnt", mispredict_cnt, 32'd6);
        idle();
        cycle();

        // Same-index lookup and update: old value now, new value next cycle.
        pred_pc = 32'h508;
        set_br(3'b000, 32'h508, 32'h600, 1'b0, 32'd3, 32'd3, 2'd0, 32'd0);
        #1;
        check("same_idx_old", pred_taken, 1'b0);
        cycle();
        check("same_idx_new", pred_taken, 1'b1);
        check("same_idx_redirect_pc", redirect_pc, 32'h600);
        idle();
        cycle();

        // Reset asserted in the cycle whose edge would raise redirect.
        set_br(3'b000, 32'h508, 32'h600, 1'b0, 32'd3, 32'd3, 2'd0, 32'd0);
        #1;
        compare_outputs();
        #2;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_redirect", redirect, 1'b0);
        check("mid_rst_flush", flush, 1'b0);
        check("mid_rst_branch_cnt", branch_cnt, 32'd0);
        check("mid_rst_mispredict_cnt", mispredict_cnt, 32'd0);
        check("mid_rst_pred_taken", pred_taken, 1'b0);
        rst_n = 1'b1;
        idle();
        cycle();

        // Randomized traffic with heavy index aliasing and PC wrap.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc;
            logic [31:0] ins;
            pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 127)) * 4;
            ins = $urandom();
            ins[14:12] = 3'($urandom_range(0, 7));
            ins[6:0]   = ($urandom_range(0, 7) == 0) ? 7'($urandom()) : 7'h63;
            ex_valid      = ($urandom_range(0, 4) != 0);
            ex_instr      = ins;
            ex_pc         = pc;
            ex_target     = $urandom();
            ex_pred_taken = $urandom_range(0, 1) ? (m_bht[m_idx(pc)] >= 2) : 1'($urandom());
            rs1           = pick_val();
            rs2           = $urandom_range(0, 2) == 0 ? rs1 : pick_val();
            fwd_data      = pick_val();
            fwd_sel       = 2'($urandom());
            pred_pc       = $urandom_range(0, 1) ? pc : 32'($urandom_range(0, 127)) * 4;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
